soc_system_gpio_pio: RTL

Parametrised general-purpose I/O controller on the HPS-to-FPGA lightweight Avalon-MM bus. Successor to the fixed 3-bit output-only PIO. Adds configurable width, per-bit direction, atomic set/clear, synchronised inputs with edge capture, and a maskable interrupt. Sits beside the other soc_system PIO slaves and drives board LEDs, buttons and headers through top-level tristate logic.

---
 rtl/soc_system_pio_pkg.sv | 24 ++
 rtl/soc_system_pio_sync.sv | 45 ++++
 rtl/soc_system_gpio_pio.sv | 129 ++++++++++++
 3 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the soc_system GPIO PIO: register word offsets and
// the edge-detect / interrupt mode encodings used as parameter values.
package soc_system_pio_pkg;

  // Register word offsets on the lightweight Avalon-MM bus.
  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  // EDGE_TYPE encodings.
  localparam int EDGE_NONE = 0;
  localparam int EDGE_RISE = 1;
  localparam int EDGE_FALL = 2;
  localparam int EDGE_ANY  = 3;

  // IRQ_TYPE encodings.
  localparam int IRQ_NONE  = 0;
  localparam int IRQ_LEVEL = 1;
  localparam int IRQ_EDGE  = 2;

endpackage

// File: rtl/soc_system_pio_sync.sv
// Input path of the GPIO PIO: a SYNC_STAGES-deep synchroniser per pin,
// followed by one history flop used to detect edges on the synchronised value.
module soc_system_pio_sync
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 3,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] hist_q;

  // Synchroniser chain plus history flop; all cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      hist_q <= '0;
    end else begin
      stage_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      hist_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync_in = stage_q[SYNC_STAGES-1];

  // One-cycle edge pulse from the last sync stage against its history.
  always_comb begin
    edge_pulse = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_pulse = sync_in & ~hist_q;
      EDGE_FALL: edge_pulse = ~sync_in & hist_q;
      EDGE_ANY:  edge_pulse = sync_in ^ hist_q;
      default:   edge_pulse = '0;
    endcase
  end

endmodule

// File: rtl/soc_system_gpio_pio.sv
// Parametrised GPIO controller on the HPS-to-FPGA lightweight Avalon-MM bus:
// output data with atomic set/clear, per-bit direction, synchronised inputs
// with edge capture, and a maskable interrupt.
//
// Bus handshake: there is no backpressure. A write is accepted at any rising
// edge where chipselect=1 and write_n=0; a read is combinational and valid in
// the same cycle the address is presented with chipselect asserted.
module soc_system_gpio_pio
  import soc_system_pio_pkg::*;
#(
  parameter int               WIDTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               IRQ_TYPE    = IRQ_EDGE,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] port_oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] dir_q,  dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_val;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];
  // Bits above WIDTH-1 are deliberately ignored.
  assign unused_wdata = ^writedata;

  soc_system_pio_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_port    (in_port),
    .sync_in    (sync_in),
    .edge_pulse (edge_pulse)
  );

  // Next-state for data_out: plain load, atomic OR-set and AND-NOT-clear.
  always_comb begin
    data_d = data_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA: data_d = wdata;
        ADDR_SET:  data_d = data_q | wdata;
        ADDR_CLR:  data_d = data_q & ~wdata;
        default:   data_d = data_q;
      endcase
    end
  end

  // Next-state for direction and mask; the mask is inert without an irq mode.
  always_comb begin
    dir_d  = dir_q;
    mask_d = mask_q;
    if (wr_en && address == ADDR_DIR) dir_d = wdata;
    if (wr_en && address == ADDR_MASK && IRQ_TYPE != IRQ_NONE) mask_d = wdata;
  end

  // Edge capture: write-1-to-clear first, then OR in new edges so a set wins.
  always_comb begin
    edge_d = edge_q;
    if (wr_en && address == ADDR_EDGE) edge_d = edge_q & ~wdata;
    edge_d = edge_d | edge_pulse;
    if (EDGE_TYPE == EDGE_NONE) edge_d = '0;
  end

  // Register bank; reset drops every register, including pending captures.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= RESET_VALUE;
      dir_q  <= '0;
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      data_q <= data_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
    end
  end

  assign out_port = data_q;
  assign port_oe  = dir_q;

  // Read mux: zero wait states, unused bits and unmapped offsets read as 0.
  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA: rd_val = (data_q & dir_q) | (sync_in & ~dir_q);
      ADDR_DIR:  rd_val = dir_q;
      ADDR_MASK: rd_val = mask_q;
      ADDR_EDGE: rd_val = edge_q;
      default:   rd_val = '0;
    endcase
    readdata = '0;
    readdata[WIDTH-1:0] = rd_val;
  end

  // Interrupt from registered state only; no combinational path from the bus.
  always_comb begin
    irq = 1'b0;
    case (IRQ_TYPE)
      IRQ_LEVEL: irq = |(sync_in & mask_q);
      IRQ_EDGE:  irq = |(edge_q & mask_q);
      default:   irq = 1'b0;
    endcase
  end

endmodule
